n64_vinfo_detect: RTL and testbench

//  Upstream of the line multiplier: measures N64 sync timing and classifies the video mode.

---
 rtl/n64_vinfo_detect.sv | 133 +++++++++++++
 tb/tb_n64_vinfo_detect.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/n64_vinfo_detect.sv
// Measures N64 sync timing and classifies the video mode as {pal_mode, interlaced}.
// Latency: outputs register on the edge that samples a qualified nVS falling edge and are visible 1 VCLK later.
// Backpressure: none; nVDSYNC qualifies samples, and cycles with nVDSYNC high leave all state untouched.
module n64_vinfo_detect #(
  parameter int                    LCNT_WIDTH         = 10,
  parameter logic [LCNT_WIDTH-1:0] PAL_LINE_THRESHOLD = 10'd288,
  parameter int                    STABLE_FIELDS      = 2
) (
  input  logic                  VCLK,
  input  logic                  nVRST,
  input  logic                  nVDSYNC,
  input  logic                  nVS_i,
  input  logic                  nHS_i,
  output logic [1:0]            vinfo_o,
  output logic                  vinfo_valid,
  output logic                  frame_id,
  output logic [LCNT_WIDTH-1:0] field_lines
);

  localparam int                    SW       = $clog2(STABLE_FIELDS + 1);
  localparam logic [SW-1:0]         STAB_MAX = SW'(STABLE_FIELDS);
  localparam logic [LCNT_WIDTH-1:0] LCNT_MAX = {LCNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {WAIT, COUNT, LOCKED} state_t;

  state_t                state_q, state_d;
  logic                  nvs_buf_q, nvs_buf_d;
  logic                  nhs_buf_q, nhs_buf_d;
  logic [LCNT_WIDTH-1:0] line_cnt_q, line_cnt_d;
  logic [LCNT_WIDTH-1:0] field_lines_q, field_lines_d;
  logic                  frame_id_q, frame_id_d;
  logic                  last_fid_q, last_fid_d;
  logic [1:0]            cand_q, cand_d;
  logic [SW-1:0]         stab_cnt_q, stab_cnt_d;
  logic [1:0]            vinfo_q, vinfo_d;
  logic                  valid_q, valid_d;

  logic       neg_vs, neg_hs;
  logic [1:0] cand_new;

  // Qualified sync edges and the classification of the field that is ending now
  always_comb begin
    neg_vs   = ~nVDSYNC & nvs_buf_q & ~nVS_i;
    neg_hs   = ~nVDSYNC & nhs_buf_q & ~nHS_i;
    cand_new = {(line_cnt_q > PAL_LINE_THRESHOLD), (neg_hs != last_fid_q)};
  end

  // Next-state: line counting, field-end capture, hysteresis FSM and sync-loss detection
  always_comb begin
    state_d       = state_q;
    nvs_buf_d     = nvs_buf_q;
    nhs_buf_d     = nhs_buf_q;
    line_cnt_d    = line_cnt_q;
    field_lines_d = field_lines_q;
    frame_id_d    = frame_id_q;
    last_fid_d    = last_fid_q;
    cand_d        = cand_q;
    stab_cnt_d    = stab_cnt_q;
    vinfo_d       = vinfo_q;
    valid_d       = valid_q;
    if (!nVDSYNC) begin
      nvs_buf_d = nVS_i;
      nhs_buf_d = nHS_i;
      if (neg_vs) begin
        // Field boundary takes priority over a coincident hsync: that line is not counted
        frame_id_d    = neg_hs;
        field_lines_d = line_cnt_q;
        line_cnt_d    = '0;
        last_fid_d    = neg_hs;
        if (state_q == WAIT) begin
          // First edge only establishes a field reference; its line count is partial
          stab_cnt_d = '0;
          state_d    = COUNT;
        end else begin
          if (cand_new == cand_q) begin
            stab_cnt_d = (stab_cnt_q == STAB_MAX) ? STAB_MAX : stab_cnt_q + SW'(1);
          end else begin
            cand_d     = cand_new;
            stab_cnt_d = SW'(1);
          end
          if (stab_cnt_d == STAB_MAX) begin
            vinfo_d = cand_new;
            valid_d = 1'b1;
            state_d = LOCKED;
          end
        end
      end else if (neg_hs && (line_cnt_q != LCNT_MAX)) begin
        line_cnt_d = line_cnt_q + LCNT_WIDTH'(1);
        if (line_cnt_d == LCNT_MAX) begin
          // No vsync for a full counter range: timing is lost, keep last mode but drop valid
          valid_d    = 1'b0;
          stab_cnt_d = '0;
          state_d    = WAIT;
        end
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge VCLK) begin
    if (!nVRST) begin
      state_q       <= WAIT;
      nvs_buf_q     <= 1'b1;
      nhs_buf_q     <= 1'b1;
      line_cnt_q    <= '0;
      field_lines_q <= '0;
      frame_id_q    <= 1'b0;
      last_fid_q    <= 1'b0;
      cand_q        <= 2'b00;
      stab_cnt_q    <= '0;
      vinfo_q       <= 2'b00;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      nvs_buf_q     <= nvs_buf_d;
      nhs_buf_q     <= nhs_buf_d;
      line_cnt_q    <= line_cnt_d;
      field_lines_q <= field_lines_d;
      frame_id_q    <= frame_id_d;
      last_fid_q    <= last_fid_d;
      cand_q        <= cand_d;
      stab_cnt_q    <= stab_cnt_d;
      vinfo_q       <= vinfo_d;
      valid_q       <= valid_d;
    end
  end

  assign vinfo_o     = vinfo_q;
  assign vinfo_valid = valid_q;
  assign frame_id    = frame_id_q;
  assign field_lines = field_lines_q;

endmodule

// File: tb/tb_n64_vinfo_detect.sv
// Directed bench for n64_vinfo_detect: table of fields with hand-computed results plus corner sequences.
// Latency: checks sample 1 time unit after the VCLK edge that registers each field end.
// Backpressure: nVDSYNC stalls are exercised explicitly in a hand-written sequence.
module tb_n64_vinfo_detect;

  logic       VCLK = 1'b0;
  logic       nVRST = 1'b0;
  logic       nVDSYNC = 1'b0;
  logic       nVS_i = 1'b1;
  logic       nHS_i = 1'b1;
  logic [1:0] vinfo_o;
  logic       vinfo_valid;
  logic       frame_id;
  logic [9:0] field_lines;

  int n_checks = 0;
  int n_fail   = 0;

  n64_vinfo_detect dut (
    .VCLK        (VCLK),
    .nVRST       (nVRST),
    .nVDSYNC     (nVDSYNC),
    .nVS_i       (nVS_i),
    .nHS_i       (nHS_i),
    .vinfo_o     (vinfo_o),
    .vinfo_valid (vinfo_valid),
    .frame_id    (frame_id),
    .field_lines (field_lines)
  );

  always #5 VCLK = ~VCLK;

  typedef struct {
    int         n;
    logic       c;
    logic [1:0] vi;
    logic       vld;
    logic       fid;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic vs, input logic hs, input logic ds);
    nVS_i   = vs;
    nHS_i   = hs;
    nVDSYNC = ds;
    @(posedge VCLK);
    #1;
  endtask

  task automatic lines(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0);
    end
  endtask

  task automatic vsync(input logic coinc);
    step(1'b0, ~coinc, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    // n lines, coincident hsync at vsync, expected vinfo, valid, frame_id; field_lines == n
    tbl[0]  = '{263, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[1]  = '{263, 1'b0, 2'b00, 1'b0, 1'b0};
    tbl[2]  = '{263, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{313, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[4]  = '{263, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[5]  = '{313, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[6]  = '{313, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[7]  = '{312, 1'b1, 2'b10, 1'b1, 1'b1};
    tbl[8]  = '{313, 1'b0, 2'b11, 1'b1, 1'b0};
    tbl[9]  = '{312, 1'b1, 2'b11, 1'b1, 1'b1};
    tbl[10] = '{262, 1'b0, 2'b11, 1'b1, 1'b0};
    tbl[11] = '{262, 1'b1, 2'b01, 1'b1, 1'b1};
    tbl[12] = '{263, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[13] = '{313, 1'b0, 2'b01, 1'b1, 1'b0};
    tbl[14] = '{313, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[15] = '{288, 1'b0, 2'b10, 1'b1, 1'b0};
    tbl[16] = '{288, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[17] = '{289, 1'b0, 2'b00, 1'b1, 1'b0};
    tbl[18] = '{289, 1'b0, 2'b10, 1'b1, 1'b0};

    // Reset state
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("reset vinfo", vinfo_o, 0);
    chk("reset valid", vinfo_valid, 0);
    chk("reset frame_id", frame_id, 0);
    chk("reset field_lines", field_lines, 0);
    nVRST = 1'b1;

    // Mode sequence: 240p lock, hysteresis, 576i, 480i, 288p, PAL threshold boundary
    for (int i = 0; i < 19; i++) begin
      lines(tbl[i].n);
      vsync(tbl[i].c);
      chk($sformatf("vec%0d vinfo", i), vinfo_o, tbl[i].vi);
      chk($sformatf("vec%0d valid", i), vinfo_valid, tbl[i].vld);
      chk($sformatf("vec%0d frame_id", i), frame_id, tbl[i].fid);
      chk($sformatf("vec%0d field_lines", i), field_lines, tbl[i].n);
    end

    // Sync loss: valid drops exactly when the line counter saturates, mode is held
    lines(1022);
    chk("pre-sat valid", vinfo_valid, 1);
    lines(1);
    chk("sat valid", vinfo_valid, 0);
    chk("sat vinfo held", vinfo_o, 2);
    lines(5);
    vsync(1'b0);
    chk("resume field_lines", field_lines, 1023);
    chk("resume valid", vinfo_valid, 0);
    lines(313);
    vsync(1'b0);
    chk("relock edge2 valid", vinfo_valid, 0);
    lines(313);
    vsync(1'b0);
    chk("relock edge3 valid", vinfo_valid, 1);
    chk("relock vinfo", vinfo_o, 2);

    // nVDSYNC stalls: pulses wholly inside a stall are invisible, a stalled vsync is seen later
    lines(100);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
    end
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("stall field_lines", field_lines, 313);
    chk("stall frame_id", frame_id, 0);
    step(1'b0, 1'b0, 1'b0);
    chk("unstall field_lines", field_lines, 100);
    chk("unstall frame_id", frame_id, 1);
    chk("unstall vinfo", vinfo_o, 2);
    chk("unstall valid", vinfo_valid, 1);
    step(1'b1, 1'b1, 1'b0);

    // Reset mid-field discards the partial count and clears outputs
    lines(50);
    nVRST = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    nVRST = 1'b1;
    chk("midreset vinfo", vinfo_o, 0);
    chk("midreset valid", vinfo_valid, 0);
    chk("midreset frame_id", frame_id, 0);
    chk("midreset field_lines", field_lines, 0);
    lines(7);
    vsync(1'b0);
    chk("post-reset field_lines", field_lines, 7);
    chk("post-reset valid", vinfo_valid, 0);
    lines(263);
    vsync(1'b0);
    chk("post-reset edge2 valid", vinfo_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
